ts_rx_chk: RTL
==============

// Module: ts_rx_chk
// PURPOSE
// - Receive-side counterpart of the TS1/TS2 generator: consumes 128-bit TS words
//   (16 symbols, symbol 0 in bits [127:120]) from the RX lane path.
// - Decodes each word as TS1, TS2 or invalid, and counts consecutive matching TSs
//   against an LTSSM-programmed expectation.
// - Reports rcvd_enough to the LTSSM once the target count is reached, and exports
//   the link number and rate fields of the last matching TS.
// PARAMETERS
// - CNT_W  16  width of the match counter and of cfg_target
// PORTS
// - clk              in   1      system clock (1 GHz)
// - rst_n            in   1      asynchronous reset, active low
// - cfg_update       in   1      LTSSM requests a new expectation; level, held until ack
// - cfg_update_ack   out  1      one-cycle acknowledge
// - cfg_ts_type      in   1      expected type: 0 = TS1, 1 = TS2
// - cfg_link_chk     in   1      1 = link number (sym1) must be non-PAD
// - cfg_target       in   CNT_W  consecutive matches required
// - rx_valid         in   1      rx_ts valid this cycle; no backpressure, always accepted
// - rx_ts            in   128    received TS word
// - rcvd_enough      out  1      target reached; sticky until next cfg accept
// - match_cnt        out  CNT_W  current consecutive-match count
// - ts_kind          out  2      last decoded word: 00 none, 01 TS1, 10 TS2, 11 invalid
// - rx_link_num      out  8      sym1 of last matching TS
// - rx_rate          out  6      sym4[5:0] of last matching TS
// - ts_err           out  1      one-cycle pulse when a valid word decodes invalid
// BEHAVIOUR
// - Reset (async, rst_n = 0): state IDLE; all outputs 0; expectation regs 0; ref symbols 0.
// - Decode (combinational on rx_ts):
//   - TS1 = sym0 == `COM (8'hBC) and sym6..15 all `TS1_IDTFR (8'h4A).
//   - TS2 = same, with sym6..15 all `TS2_IDTFR (8'h45).
//   - Anything else = invalid.
// - A word matches when:
//   - its decoded type equals cfg_ts_type, and
//   - cfg_link_chk = 0 or sym1 != `PADG12 (8'hF7).
// - States:
//   - IDLE:
//     - cfg_update = 1 -> latch cfg_*, clear match_cnt and rcvd_enough, ack = 1 next cycle, go COUNT.
//     - rx words are ignored; ts_kind still updates.
//   - COUNT, cfg_update = 1 and ack_reg = 0 (new request):
//     - re-latch cfg_*, ack pulse, clear match_cnt and rcvd_enough.
//     - An rx word in that same cycle is dropped; config has priority.
//   - COUNT, otherwise: ack = 0; process rx words as below.
// - Per valid word in COUNT (results visible the cycle after rx_valid):
//   - ts_kind updates to the decoded type.
//   - Match, with sym1..5 equal to the stored ref (or match_cnt == 0):
//     - match_cnt += 1, saturating at all-ones.
//     - ref and rx_link_num/rx_rate take this word's fields.
//   - Match, but sym1..5 differ from ref: match_cnt = 1; ref and outputs take the new fields.
//   - Non-match, valid type: match_cnt = 0; rx_link_num/rx_rate hold.
//   - Invalid decode: match_cnt = 0; ts_err pulses for one cycle.
// - rcvd_enough:
//   - Set on the edge where the new match_cnt >= cfg_target; stays set even if matches then break.
//   - cfg_target = 0 -> set one cycle after entering COUNT, with no rx word needed.
// - Gaps (rx_valid = 0) do not break consecutiveness; count holds.
// - cfg_update held beyond ack causes no repeated ack or clear.
//   - It must drop for at least one cycle before the next request.
// - Async reset mid-count clears everything immediately; no partial state survives.
// TESTING
// - Reset, then cfg(TS1, target 8) and 8 identical TS1 (link PAD, rate 6'h02):
//   - rcvd_enough rises the cycle after word 8; match_cnt = 8; ack seen once.
// - 5 TS1 then 1 TS2 with expect TS1:
//   - match_cnt 5 -> 0; ts_kind = 10; rcvd_enough stays 0.
// - Word with sym0 = 8'h00:
//   - ts_err pulses one cycle; ts_kind = 11; match_cnt = 0.
// - cfg_link_chk = 1, TS2 with sym1 = 8'hF7, then sym1 = 8'h01 x4, target 4:
//   - PAD word gives no count; enough after 4th; rx_link_num = 8'h01.
// - 3 TS1 rate 02, then TS1 rate 06:
//   - match_cnt = 1; rx_rate = 6'h06.
// - Mid-count cfg_update(TS2, target 0) coincident with rx_valid:
//   - word dropped; match_cnt = 0; rcvd_enough = 1 one cycle after ack; rst_n low mid-run clears all.

Source files
------------

// File: rtl/ts_rx_chk.sv
// Receive-side TS1/TS2 checker: decodes 128-bit TS words and counts consecutive
// matches against an LTSSM-programmed expectation, flagging rcvd_enough at target.
module ts_rx_chk #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_update,
  output logic             cfg_update_ack,
  input  logic             cfg_ts_type,
  input  logic             cfg_link_chk,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             rx_valid,
  input  logic [127:0]     rx_ts,
  output logic             rcvd_enough,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       ts_kind,
  output logic [7:0]       rx_link_num,
  output logic [5:0]       rx_rate,
  output logic             ts_err,
  output logic             dbg_state
);

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] TS1_IDTFR = 8'h4A;
  localparam logic [7:0] TS2_IDTFR = 8'h45;
  localparam logic [7:0] PADG12    = 8'hF7;

  localparam logic [1:0] KIND_TS1 = 2'b01;
  localparam logic [1:0] KIND_TS2 = 2'b10;
  localparam logic [1:0] KIND_INV = 2'b11;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  // Handshake: cfg_update is a level the LTSSM holds until it sees the one-cycle
  // cfg_update_ack; a request is accepted only after cfg_update has been seen low
  // since the previous accept (r_cfg_hold), so a held level never re-triggers.
  state_t           r_state;
  logic             r_ack;
  logic             r_cfg_hold;
  logic             r_ts_type;
  logic             r_link_chk;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_cnt;
  logic             r_enough;
  logic [1:0]       r_kind;
  logic [7:0]       r_link;
  logic [5:0]       r_rate;
  logic             r_err;
  logic [39:0]      r_ref;

  logic [1:0]       w_kind;
  logic             w_match;
  logic             w_same_ref;
  logic             w_new_req;
  logic [CNT_W-1:0] w_new_cnt;

  always_comb begin
    w_kind = KIND_INV;
    if (rx_ts[127:120] == COM) begin
      if (rx_ts[79:0] == {10{TS1_IDTFR}})      w_kind = KIND_TS1;
      else if (rx_ts[79:0] == {10{TS2_IDTFR}}) w_kind = KIND_TS2;
    end
  end

  assign w_match    = (w_kind == (r_ts_type ? KIND_TS2 : KIND_TS1)) &&
                      (!r_link_chk || (rx_ts[119:112] != PADG12));
  assign w_same_ref = (rx_ts[119:80] == r_ref) || (r_cnt == '0);
  assign w_new_req  = cfg_update && !r_cfg_hold;

  // Count this cycle would leave behind; also drives the rcvd_enough compare.
  always_comb begin
    w_new_cnt = r_cnt;
    if (rx_valid) begin
      if (w_match && w_same_ref) w_new_cnt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      else if (w_match)          w_new_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
      else                       w_new_cnt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_cfg_hold <= 1'b0;
      r_ts_type  <= 1'b0;
      r_link_chk <= 1'b0;
      r_target   <= '0;
      r_cnt      <= '0;
      r_enough   <= 1'b0;
      r_kind     <= 2'b00;
      r_link     <= 8'h00;
      r_rate     <= 6'h00;
      r_err      <= 1'b0;
      r_ref      <= '0;
    end else begin
      r_err <= 1'b0;
      r_ack <= 1'b0;
      if (!cfg_update) r_cfg_hold <= 1'b0;
      if (w_new_req) begin
        r_state    <= COUNT;
        r_ack      <= 1'b1;
        r_cfg_hold <= 1'b1;
        r_ts_type  <= cfg_ts_type;
        r_link_chk <= cfg_link_chk;
        r_target   <= cfg_target;
        r_cnt      <= '0;
        r_enough   <= 1'b0;
        if (r_state == IDLE && rx_valid) r_kind <= w_kind;
      end else if (r_state == IDLE) begin
        if (rx_valid) r_kind <= w_kind;
      end else begin
        r_cnt <= w_new_cnt;
        if (w_new_cnt >= r_target) r_enough <= 1'b1;
        if (rx_valid) begin
          r_kind <= w_kind;
          if (w_match) begin
            r_ref  <= rx_ts[119:80];
            r_link <= rx_ts[119:112];
            r_rate <= rx_ts[93:88];
          end
          if (w_kind == KIND_INV) r_err <= 1'b1;
        end
      end
    end
  end

  assign cfg_update_ack = r_ack;
  assign rcvd_enough    = r_enough;
  assign match_cnt      = r_cnt;
  assign ts_kind        = r_kind;
  assign rx_link_num    = r_link;
  assign rx_rate        = r_rate;
  assign ts_err         = r_err;
  assign dbg_state      = r_state;

endmodule
